// File: rtl/charge_ctrl_pkg.sv
// Shared types and constants for the charge-session controller.
package charge_ctrl_pkg;

    localparam int STATE_W         = 3;
    localparam int LEVEL_W_DEFAULT = 4;

    // Session states; the encoding is visible on state_o.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_RAMP     = 3'd1,
        ST_CHARGE   = 3'd2,
        ST_LOCKOUT  = 3'd3,
        ST_DRY_WAIT = 3'd4,
        ST_BACKOFF  = 3'd5,
        ST_LATCHED  = 3'd6
    } state_t;

    // States in which current may flow to the power stage.
    function automatic logic is_active(input state_t s);
        return (s == ST_RAMP) || (s == ST_CHARGE);
    endfunction

endpackage

// File: rtl/sig_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer.
// The debounced value only follows the synced value after it has
// disagreed for DEBOUNCE_CYCLES edges in a row.
module sig_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic debounced
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             synced;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous input into the clk domain.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= 1'b0;
            synced <= 1'b0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

    // Count consecutive disagreeing edges; flip on the last one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            debounced <= 1'b0;
        end else if (synced == debounced) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt       <= '0;
            debounced <= synced;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/charge_session_ctrl.sv
// Charge-session sequencer: moisture lockout with dry hold, soft-start
// current ramp, and fault retry with backoff and latch-off.
module charge_session_ctrl
    import charge_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int DRY_HOLD_CYCLES  = 1024,
    parameter int RAMP_STEP_CYCLES = 64,
    parameter int BACKOFF_CYCLES   = 256,
    parameter int LEVEL_W          = LEVEL_W_DEFAULT,
    parameter int MAX_RETRIES      = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               moisture_sensor,
    input  logic               charger_plugged,
    input  logic               fault_in,
    input  logic [LEVEL_W-1:0] level_limit,
    output logic               charge_enable,
    output logic [LEVEL_W-1:0] charge_level,
    output logic [STATE_W-1:0] state_o,
    output logic               moisture_lockout,
    output logic               retry_exhausted
);

    localparam int STEP_W  = $clog2(RAMP_STEP_CYCLES + 1);
    localparam int DRY_W   = $clog2(DRY_HOLD_CYCLES + 1);
    localparam int BOFF_W  = $clog2(BACKOFF_CYCLES + 1);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [DRY_W-1:0]   DRY_LOAD  = DRY_W'(DRY_HOLD_CYCLES - 1);
    localparam logic [BOFF_W-1:0]  BOFF_LAST = BOFF_W'(BACKOFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    logic plug_meta, plug_sync;
    logic moist_deb;

    state_t               state, next_state;
    logic [LEVEL_W-1:0]   level, next_level;
    logic [STEP_W-1:0]    step_cnt, next_step;
    logic [DRY_W-1:0]     dry_cnt, next_dry;
    logic [BOFF_W-1:0]    boff_cnt, next_boff;
    logic [RETRY_W-1:0]   retry_cnt, next_retry;

    sig_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_moist_deb (
        .clk      (clk),
        .reset_n  (reset_n),
        .raw      (moisture_sensor),
        .debounced(moist_deb)
    );

    // Plug detect only needs synchronising, not debouncing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plug_meta <= 1'b0;
            plug_sync <= 1'b0;
        end else begin
            plug_meta <= charger_plugged;
            plug_sync <= plug_meta;
        end
    end

    // Next-state, level and counter logic in priority order: unplug, moisture, fault.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        next_state = state;
        next_level = level;
        next_step  = step_cnt;
        next_dry   = dry_cnt;
        next_boff  = boff_cnt;
        next_retry = retry_cnt;

        if (!plug_sync) begin
            next_state = ST_IDLE;
            next_level = '0;
            next_step  = '0;
            next_dry   = '0;
            next_boff  = '0;
            next_retry = '0;
        end else if (moist_deb && state != ST_LATCHED) begin
            next_state = ST_LOCKOUT;
            next_level = '0;
        end else if (fault_in && is_active(state)) begin
            next_retry = (retry_cnt < RETRY_MAX) ? retry_cnt + RETRY_W'(1) : retry_cnt;
            next_state = (next_retry == RETRY_MAX) ? ST_LATCHED : ST_BACKOFF;
            next_level = '0;
            next_boff  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_RAMP;
                    next_level = '0;
                    next_step  = '0;
                end
                ST_RAMP: begin
                    if (level >= level_limit) begin
                        next_level = level_limit;
                        next_state = ST_CHARGE;
                    end else if (step_cnt == STEP_LAST) begin
                        next_level = level + LEVEL_W'(1);
                        next_step  = '0;
                    end else begin
                        next_step = step_cnt + STEP_W'(1);
                    end
                end
                ST_CHARGE: begin
                    if (level_limit < level) begin
                        next_level = level_limit;
                    end else if (level_limit > level) begin
                        next_state = ST_RAMP;
                        next_step  = '0;
                    end
                end
                ST_LOCKOUT: begin
                    // Reaching here means the debounced moisture has fallen.
                    next_level = '0;
                    next_state = ST_DRY_WAIT;
                    next_dry   = DRY_LOAD;
                end
                ST_DRY_WAIT: begin
                    next_level = '0;
                    if (dry_cnt == '0) begin
                        next_state = ST_RAMP;
                        next_step  = '0;
                    end else begin
                        next_dry = dry_cnt - DRY_W'(1);
                    end
                end
                ST_BACKOFF: begin
                    next_level = '0;
                    if (boff_cnt == BOFF_LAST) begin
                        next_state = ST_RAMP;
                        next_step  = '0;
                    end else begin
                        next_boff = boff_cnt + BOFF_W'(1);
                    end
                end
                ST_LATCHED: begin
                    next_level = '0;
                end
                default: begin
                    next_state = ST_IDLE;
                    next_level = '0;
                    next_step  = '0;
                    next_dry   = '0;
                    next_boff  = '0;
                    next_retry = '0;
                end
            endcase
        end
    end

    // State, counters and outputs all update together from the next-state values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= ST_IDLE;
            level            <= '0;
            step_cnt         <= '0;
            dry_cnt          <= '0;
            boff_cnt         <= '0;
            retry_cnt        <= '0;
            charge_enable    <= 1'b0;
            moisture_lockout <= 1'b0;
            retry_exhausted  <= 1'b0;
        end else begin
            state            <= next_state;
            level            <= next_level;
            step_cnt         <= next_step;
            dry_cnt          <= next_dry;
            boff_cnt         <= next_boff;
            retry_cnt        <= next_retry;
            charge_enable    <= is_active(next_state) && (next_level != '0);
            moisture_lockout <= (next_state == ST_LOCKOUT) || (next_state == ST_DRY_WAIT);
            retry_exhausted  <= (next_state == ST_LATCHED);
        end
    end

    assign charge_level = level;
    assign state_o      = state;

endmodule

// File: tb/tb_charge_session_ctrl.sv
// Bench for charge_session_ctrl: a scripted session table, hand-written
// corner sequences, then random stimulus against a deadline-based model.
module tb_charge_session_ctrl;

    localparam int DEB = 4, DRY = 8, STEP = 2, BOFF = 5, LW = 4, RETRIES = 2;
    localparam int S_IDLE = 0, S_RAMP = 1, S_CHARGE = 2, S_LOCKOUT = 3;
    localparam int S_DRY = 4, S_BACKOFF = 5, S_LATCHED = 6;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          moisture_sensor = 1'b0;
    logic          charger_plugged = 1'b0;
    logic          fault_in = 1'b0;
    logic [LW-1:0] level_limit = '0;
    logic          charge_enable;
    logic [LW-1:0] charge_level;
    logic [2:0]    state_o;
    logic          moisture_lockout;
    logic          retry_exhausted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    charge_session_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .DRY_HOLD_CYCLES (DRY),
        .RAMP_STEP_CYCLES(STEP),
        .BACKOFF_CYCLES  (BOFF),
        .LEVEL_W         (LW),
        .MAX_RETRIES     (RETRIES)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .moisture_sensor (moisture_sensor),
        .charger_plugged (charger_plugged),
        .fault_in        (fault_in),
        .level_limit     (level_limit),
        .charge_enable   (charge_enable),
        .charge_level    (charge_level),
        .state_o         (state_o),
        .moisture_lockout(moisture_lockout),
        .retry_exhausted (retry_exhausted)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Outputs packed as {state, level, enable, lockout, exhausted}.
    function automatic int pack(input int st, input int lvl, input int en, input int lk, input int ex);
        return (st << 7) | (lvl << 3) | (en << 2) | (lk << 1) | ex;
    endfunction

    function automatic int dut_vec();
        return pack(int'(state_o), int'(charge_level), int'(charge_enable),
                    int'(moisture_lockout), int'(retry_exhausted));
    endfunction

    // ---------------- reference model ----------------
    // Synchronisers are plain sample delays, debounce is "last DEB synced
    // samples all disagree", and timers are absolute-cycle deadlines.
    int m_cyc, m_state, m_level, m_retry, m_next_step, m_deadline;
    bit m_p1, m_p2, m_s1, m_s2, m_deb;
    bit m_hist[$];

    task automatic model_reset();
        m_cyc = 0; m_state = S_IDLE; m_level = 0; m_retry = 0;
        m_next_step = 0; m_deadline = 0;
        m_p1 = 0; m_p2 = 0; m_s1 = 0; m_s2 = 0; m_deb = 0;
        m_hist.delete();
    endtask

    task automatic model_step();
        bit plug_s, deb, flt, agree;
        int lim;
        m_cyc++;
        plug_s = m_p2; deb = m_deb; flt = fault_in; lim = int'(level_limit);
        if (!plug_s) begin
            m_state = S_IDLE; m_level = 0; m_retry = 0;
        end else if (deb && m_state != S_LATCHED) begin
            m_state = S_LOCKOUT; m_level = 0;
        end else if (flt && (m_state == S_RAMP || m_state == S_CHARGE)) begin
            m_retry++;
            m_level = 0;
            m_state = (m_retry == RETRIES) ? S_LATCHED : S_BACKOFF;
            m_deadline = m_cyc + BOFF;
        end else begin
            case (m_state)
                S_IDLE: begin
                    m_state = S_RAMP; m_level = 0; m_next_step = m_cyc + STEP;
                end
                S_RAMP: begin
                    if (m_level >= lim) begin
                        m_level = lim; m_state = S_CHARGE;
                    end else if (m_cyc == m_next_step) begin
                        m_level++; m_next_step = m_cyc + STEP;
                    end
                end
                S_CHARGE: begin
                    if (lim < m_level) m_level = lim;
                    else if (lim > m_level) begin
                        m_state = S_RAMP; m_next_step = m_cyc + STEP;
                    end
                end
                S_LOCKOUT: begin
                    m_state = S_DRY; m_deadline = m_cyc + DRY;
                end
                S_DRY, S_BACKOFF: begin
                    if (m_cyc == m_deadline) begin
                        m_state = S_RAMP; m_level = 0; m_next_step = m_cyc + STEP;
                    end
                end
                default: ;
            endcase
        end
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        if (m_hist.size() == DEB) begin
            agree = 1;
            foreach (m_hist[i]) if (m_hist[i] == m_deb) agree = 0;
            if (agree) m_deb = ~m_deb;
        end
        m_s2 = m_s1; m_s1 = moisture_sensor;
        m_p2 = m_p1; m_p1 = charger_plugged;
    endtask

    function automatic int model_vec();
        return pack(m_state, m_level,
                    int'((m_state == S_RAMP || m_state == S_CHARGE) && m_level != 0),
                    int'(m_state == S_LOCKOUT || m_state == S_DRY),
                    int'(m_state == S_LATCHED));
    endfunction

    // One clock edge; outputs are safe to sample on return.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        charger_plugged = 1'b0; moisture_sensor = 1'b0; fault_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("in_reset", dut_vec(), 0);
        reset_n = 1'b1;
    endtask

    // ---------------- session table ----------------
    typedef struct {
        bit plug; bit moist; bit flt; int lim; int n;
        int st; int lvl; bit en; bit lk; bit ex;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input bit plug, input bit moist, input bit flt, input int lim, input int n,
                       input int st, input int lvl, input bit en, input bit lk, input bit ex);
        vec_t v;
        v.plug = plug; v.moist = moist; v.flt = flt; v.lim = lim; v.n = n;
        v.st = st; v.lvl = lvl; v.en = en; v.lk = lk; v.ex = ex;
        vecs.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit moist_base;
        int glitch_left;

        //  plug moist flt lim  n   st lvl en lk ex
        add(1, 0, 0, 5,  2,  0, 0, 0, 0, 0);  // plug still in synchroniser
        add(1, 0, 0, 5,  1,  1, 0, 0, 0, 0);  // RAMP at level 0
        add(1, 0, 0, 5,  2,  1, 1, 1, 0, 0);  // first step, enable rises
        add(1, 0, 0, 5,  8,  1, 5, 1, 0, 0);
        add(1, 0, 0, 5,  1,  2, 5, 1, 0, 0);  // CHARGE at 5
        add(1, 0, 0, 5,  3,  2, 5, 1, 0, 0);
        add(1, 1, 0, 5,  3,  2, 5, 1, 0, 0);  // 3-cycle glitch
        add(1, 0, 0, 5,  6,  2, 5, 1, 0, 0);  // glitch ignored
        add(1, 1, 0, 5,  6,  2, 5, 1, 0, 0);  // 6 edges after raw rise
        add(1, 1, 0, 5,  1,  3, 0, 0, 1, 0);  // 7th edge: LOCKOUT
        add(1, 0, 0, 5,  6,  3, 0, 0, 1, 0);
        add(1, 0, 0, 5,  1,  4, 0, 0, 1, 0);  // DRY_WAIT
        add(1, 1, 0, 5,  6,  4, 0, 0, 1, 0);
        add(1, 1, 0, 5,  1,  3, 0, 0, 1, 0);  // re-assert: LOCKOUT
        add(1, 0, 0, 5,  6,  3, 0, 0, 1, 0);
        add(1, 0, 0, 5,  1,  4, 0, 0, 1, 0);
        add(1, 0, 0, 5,  7,  4, 0, 0, 1, 0);  // full hold restarted
        add(1, 0, 0, 5,  1,  1, 0, 0, 0, 0);  // RAMP from 0 after 8
        add(1, 0, 0, 5, 10,  1, 5, 1, 0, 0);
        add(1, 0, 0, 5,  1,  2, 5, 1, 0, 0);
        add(1, 0, 1, 5,  1,  5, 0, 0, 0, 0);  // first fault: BACKOFF
        add(1, 0, 0, 5,  4,  5, 0, 0, 0, 0);
        add(1, 0, 0, 5,  1,  1, 0, 0, 0, 0);  // after 5 cycles: RAMP
        add(1, 0, 0, 5, 10,  1, 5, 1, 0, 0);
        add(1, 0, 0, 5,  1,  2, 5, 1, 0, 0);
        add(1, 0, 1, 5,  1,  6, 0, 0, 0, 1);  // second fault: LATCHED
        add(1, 1, 1, 5, 10,  6, 0, 0, 0, 1);  // moisture and fault ignored
        add(1, 0, 0, 5,  8,  6, 0, 0, 0, 1);
        add(0, 0, 0, 5,  2,  6, 0, 0, 0, 1);  // unplug in synchroniser
        add(0, 0, 0, 5,  1,  0, 0, 0, 0, 0);  // IDLE
        add(1, 0, 0, 5,  3,  1, 0, 0, 0, 0);
        add(1, 0, 0, 5, 11,  2, 5, 1, 0, 0);
        add(1, 0, 1, 5,  1,  5, 0, 0, 0, 0);  // retry count was cleared
        add(1, 0, 0, 5,  5,  1, 0, 0, 0, 0);
        add(1, 0, 0, 5, 11,  2, 5, 1, 0, 0);
        add(1, 0, 0, 2,  1,  2, 2, 1, 0, 0);  // limit drop applied next edge
        add(1, 0, 0, 7,  1,  1, 2, 1, 0, 0);  // limit raise: RAMP
        add(1, 0, 0, 7,  2,  1, 3, 1, 0, 0);
        add(1, 0, 0, 7,  8,  1, 7, 1, 0, 0);
        add(1, 0, 0, 7,  1,  2, 7, 1, 0, 0);
        add(1, 0, 0, 0,  1,  2, 0, 0, 0, 0);  // target 0: CHARGE, enable low
        add(1, 0, 0, 0,  3,  2, 0, 0, 0, 0);

        do_reset();
        check("after_reset", dut_vec(), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            charger_plugged = vecs[i].plug;
            moisture_sensor = vecs[i].moist;
            fault_in        = vecs[i].flt;
            level_limit     = LW'(vecs[i].lim);
            repeat (vecs[i].n) tick();
            check($sformatf("vec[%0d]", i), dut_vec(),
                  pack(vecs[i].st, vecs[i].lvl, int'(vecs[i].en), int'(vecs[i].lk), int'(vecs[i].ex)));
        end

        // Asynchronous reset between clock edges during RAMP.
        level_limit = LW'(5);
        repeat (3) tick();
        check("pre_async_reset", dut_vec(), pack(S_RAMP, 1, 1, 0, 0));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), 0);
        do_reset();

        // Moisture debounced while unplugged, then plug: LOCKOUT, never RAMP.
        moisture_sensor = 1'b1;
        repeat (8) tick();
        charger_plugged = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("wet_plug[%0d]", i), dut_vec(),
                  (i < 2) ? 0 : pack(S_LOCKOUT, 0, 0, 1, 0));
        end
        moisture_sensor = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("dry_entry[%0d]", i), dut_vec(),
                  pack((i < 6) ? S_LOCKOUT : S_DRY, 0, 0, 1, 0));
        end
        // Unplug during DRY_WAIT.
        charger_plugged = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("dry_unplug[%0d]", i), dut_vec(),
                  (i < 2) ? pack(S_DRY, 0, 0, 1, 0) : 0);
        end

        // Random sessions against the model.
        do_reset();
        charger_plugged = 1'b1;
        level_limit = LW'(9);
        moist_base = 1'b0;
        glitch_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0) charger_plugged = ~charger_plugged;
            if (!moist_base && $urandom_range(0, 119) == 0) moist_base = 1'b1;
            else if (moist_base && $urandom_range(0, 29) == 0) moist_base = 1'b0;
            if (glitch_left == 0 && $urandom_range(0, 24) == 0)
                glitch_left = int'($urandom_range(1, DEB + 1));
            moisture_sensor = moist_base ^ (glitch_left != 0);
            if (glitch_left != 0) glitch_left--;
            fault_in = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 79) == 0) level_limit = LW'($urandom_range(0, 15));
            tick();
            check($sformatf("rand[%0d]", c), dut_vec(), model_vec());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
